// File: rtl/traceback_reader_pkg.sv
// Shared definitions for the traceback path: packet layout, source encodings, FSM states.
// The source encodings are the same values the matrix-fill processing element writes,
// so the encoder and this decoder cannot drift apart.
package traceback_reader_pkg;

  localparam int SEQ_LENGTH       = 32;
  localparam int SEQ_LENGTH_W     = 5;
  localparam int SOURCE_WIDTH     = 2;
  localparam int DATA_PACKET_SIZE = 1 + SOURCE_WIDTH;
  localparam int ADDR_W           = 2 * SEQ_LENGTH_W;
  localparam int MAX_STEPS        = 2 * SEQ_LENGTH;

  // step_count value whose next accepted op would exceed the path guard
  localparam logic [SEQ_LENGTH_W:0] STEP_LIMIT = (SEQ_LENGTH_W + 1)'(MAX_STEPS - 1);

  localparam logic [SOURCE_WIDTH-1:0] SOURCE_DIAG = 2'd0;
  localparam logic [SOURCE_WIDTH-1:0] SOURCE_TOP  = 2'd1;
  localparam logic [SOURCE_WIDTH-1:0] SOURCE_LEFT = 2'd2;
  localparam logic [SOURCE_WIDTH-1:0] SOURCE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    OP_DIAG = 2'd0,
    OP_TOP  = 2'd1,
    OP_LEFT = 2'd2
  } tb_op_e;

  typedef struct packed {
    logic                    zero_bit;
    logic [SOURCE_WIDTH-1:0] source;
  } data_packet_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT,
    ST_DRAIN,
    ST_FIN
  } tb_state_e;

  // True when following src from (row, col) would step off the matrix,
  // i.e. the op emitted for this cell is the last one of the walk.
  function automatic logic is_border_step(input logic [SOURCE_WIDTH-1:0] src,
                                          input logic [SEQ_LENGTH_W-1:0] row,
                                          input logic [SEQ_LENGTH_W-1:0] col);
    case (src)
      SOURCE_DIAG: return (row == '0) || (col == '0);
      SOURCE_TOP:  return (row == '0);
      SOURCE_LEFT: return (col == '0);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/traceback_reader.sv
// Walks back from the max-score cell through matrix_memory and emits edit operations.
// Latency: rd_req in the cycle after start is taken; best case one op per 3 cycles at read latency 1.
// Backpressure: op_* held stable while op_valid && !op_ready; one matrix read outstanding at most.
// Ports: clk/rst_n; start/start_row/start_col/abort control; rd_req/rd_addr/rd_valid/rd_data to
// matrix_memory; op_valid/op_ready/op_code/op_row/op_col/op_last to the consumer;
// busy/done/err/step_count status.
module traceback_reader
  import traceback_reader_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SEQ_LENGTH_W-1:0]       start_row,
  input  logic [SEQ_LENGTH_W-1:0]       start_col,
  input  logic                          abort,
  output logic                          rd_req,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic                          rd_valid,
  input  logic [DATA_PACKET_SIZE-1:0]   rd_data,
  output logic                          op_valid,
  input  logic                          op_ready,
  output logic [1:0]                    op_code,
  output logic [SEQ_LENGTH_W-1:0]       op_row,
  output logic [SEQ_LENGTH_W-1:0]       op_col,
  output logic                          op_last,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [SEQ_LENGTH_W:0]         step_count
);

  tb_state_e                  state, state_nxt;
  logic [SEQ_LENGTH_W-1:0]    cur_row, cur_col;
  logic [SEQ_LENGTH_W:0]      step_q;
  logic [1:0]                 op_code_q;
  logic [SEQ_LENGTH_W-1:0]    op_row_q, op_col_q;
  logic                       op_last_q;
  logic                       fin_err;
  data_packet_t               pkt;

  logic rd_take;   // read response consumed by the walk
  logic op_take;   // op accepted by the consumer (abort wins)

  assign pkt     = data_packet_t'(rd_data);
  assign rd_take = (state == ST_WAIT) && rd_valid && !abort;
  assign op_take = (state == ST_EMIT) && op_ready && !abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = abort ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (abort)        state_nxt = ST_DRAIN;
        else if (rd_valid) begin
          if (pkt.zero_bit || pkt.source == SOURCE_RSVD) state_nxt = ST_FIN;
          else                                           state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (abort) state_nxt = ST_IDLE;
        else if (op_ready) begin
          if (op_last_q || step_q == STEP_LIMIT) state_nxt = ST_FIN;
          else                                   state_nxt = ST_ISSUE;
        end
      end
      // The read already in flight must be swallowed before a new walk can issue.
      ST_DRAIN: if (rd_valid) state_nxt = ST_IDLE;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    // An abort in ISSUE suppresses the request so no response can arrive in a later walk.
    rd_req   = (state == ST_ISSUE) && !abort;
    op_valid = (state == ST_EMIT);
    busy     = (state != ST_IDLE);
    done     = (state == ST_FIN) && !fin_err && !abort;
    err      = (state == ST_FIN) &&  fin_err && !abort;
  end

  assign rd_addr    = {cur_row, cur_col};
  assign op_code    = op_code_q;
  assign op_row     = op_row_q;
  assign op_col     = op_col_q;
  assign op_last    = op_last_q;
  assign step_count = step_q;

  // Walk datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_row   <= '0;
      cur_col   <= '0;
      step_q    <= '0;
      op_code_q <= '0;
      op_row_q  <= '0;
      op_col_q  <= '0;
      op_last_q <= 1'b0;
      fin_err   <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        cur_row <= start_row;
        cur_col <= start_col;
        step_q  <= '0;
        fin_err <= 1'b0;
      end
      if (rd_take) begin
        if (pkt.zero_bit) begin
          fin_err <= 1'b0;
        end else if (pkt.source == SOURCE_RSVD) begin
          fin_err <= 1'b1;
        end else begin
          op_code_q <= pkt.source;
          op_row_q  <= cur_row;
          op_col_q  <= cur_col;
          op_last_q <= is_border_step(pkt.source, cur_row, cur_col);
        end
      end
      if (op_take) begin
        step_q <= step_q + 1'b1;
        if (op_code_q != SOURCE_LEFT) cur_row <= cur_row - 1'b1;
        if (op_code_q != SOURCE_TOP)  cur_col <= cur_col - 1'b1;
        if (!op_last_q && step_q == STEP_LIMIT) fin_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_traceback_reader.sv
module tb_traceback_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] start_row = '0;
  logic [4:0] start_col = '0;
  logic       abort = 1'b0;
  logic       rd_req;
  logic [9:0] rd_addr;
  logic       rd_valid = 1'b0;
  logic [2:0] rd_data = '0;
  logic       op_valid;
  logic       op_ready = 1'b1;
  logic [1:0] op_code;
  logic [4:0] op_row, op_col;
  logic       op_last, busy, done, err;
  logic [5:0] step_count;

  int total = 0;
  int bad   = 0;

  // memory model state
  logic [2:0] mem [0:1023];
  logic [9:0] addr_log [0:255];
  logic [9:0] pend_addr = '0;
  int rd_lat = 1;
  int pend = 0;
  int rd_cnt = 0;
  int inj_seq = 0;
  int inj_seen = 0;
  // event monitors
  int done_cnt = 0;
  int err_cnt = 0;
  int opv_cnt = 0;

  traceback_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_row(start_row), .start_col(start_col),
    .abort(abort), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_row(op_row),
    .op_col(op_col), .op_last(op_last), .busy(busy), .done(done), .err(err),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // matrix_memory model: response rd_lat cycles after the request, driven on negedges
  always @(negedge clk) begin
    rd_valid = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          rd_valid = 1'b1;
          rd_data  = mem[pend_addr];
        end
      end
      if (rd_req) begin
        addr_log[rd_cnt % 256] = rd_addr;
        rd_cnt    = rd_cnt + 1;
        pend_addr = rd_addr;
        pend      = rd_lat;
      end
      if (inj_seq != inj_seen) begin
        inj_seen = inj_seq;
        rd_valid = 1'b1;
        rd_data  = 3'b000;
      end
    end
  end

  always @(negedge clk) begin
    if (done)     done_cnt = done_cnt + 1;
    if (err)      err_cnt  = err_cnt + 1;
    if (op_valid) opv_cnt  = opv_cnt + 1;
  end

  task automatic do_start(input logic [4:0] r, input logic [4:0] c);
    @(negedge clk);
    start = 1'b1; start_row = r; start_col = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_op(output logic [1:0] code, output logic [4:0] r, output logic [4:0] c,
                         output logic last, output bit got);
    got = 1'b0; code = '0; r = '0; c = '0; last = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (op_valid) begin
        code = op_code; r = op_row; c = op_col; last = op_last; got = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({rd_req, op_valid, op_last, busy, done, err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {rd_req, op_valid, op_last, busy, done, err});
    end
    total++;
    if ({op_code, op_row, op_col, step_count, rd_addr} !== 28'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {op_code, op_row, op_col, step_count, rd_addr});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_diag_run();
    logic [1:0] code; logic [4:0] r, c; logic last; bit got, ok;
    logic [9:0] exp_addr [4];
    int base, d0, e0;
    exp_addr[0] = 10'h063; exp_addr[1] = 10'h042; exp_addr[2] = 10'h021; exp_addr[3] = 10'h000;
    mem[{5'd3, 5'd3}] = 3'b000; mem[{5'd2, 5'd2}] = 3'b000;
    mem[{5'd1, 5'd1}] = 3'b000; mem[{5'd0, 5'd0}] = 3'b100;
    base = rd_cnt; d0 = done_cnt; e0 = err_cnt;
    do_start(5'd3, 5'd3);
    for (int i = 0; i < 3; i++) begin
      wait_op(code, r, c, last, got);
      total++;
      if (!got || code !== 2'd0 || r !== 5'(3 - i) || c !== 5'(3 - i) || last !== 1'b0) begin
        bad++;
        $display("FAIL diag_op%0d: got v=%0d code=%0d (%0d,%0d) last=%0d want code=0 (%0d,%0d) last=0",
                 i, got, code, r, c, last, 3 - i, 3 - i);
      end
    end
    wait_idle(ok);
    total++;
    if (!ok || done_cnt - d0 != 1 || err_cnt != e0) begin
      bad++;
      $display("FAIL diag_end: idle=%0d done=%0d err=%0d want 1 1 0", ok, done_cnt - d0, err_cnt - e0);
    end
    total++;
    if (step_count !== 6'd3) begin
      bad++; $display("FAIL diag_steps: got %0d want 3", step_count);
    end
    total++;
    if (rd_cnt - base != 4) begin
      bad++; $display("FAIL diag_reads: got %0d want 4", rd_cnt - base);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (addr_log[(base + i) % 256] !== exp_addr[i]) begin
        bad++; $display("FAIL diag_addr%0d: got %h want %h", i, addr_log[(base + i) % 256], exp_addr[i]);
      end
    end
  endtask

  task automatic test_mixed_backpressure();
    logic [1:0] code; logic [4:0] r, c; logic last; bit got, ok;
    logic [1:0] e_code [4];
    logic [4:0] e_row [4];
    logic [4:0] e_col [4];
    logic       e_last [4];
    int base, d0;
    e_code[0] = 2'd2; e_row[0] = 5'd2; e_col[0] = 5'd4; e_last[0] = 1'b0;
    e_code[1] = 2'd1; e_row[1] = 5'd2; e_col[1] = 5'd3; e_last[1] = 1'b0;
    e_code[2] = 2'd0; e_row[2] = 5'd1; e_col[2] = 5'd3; e_last[2] = 1'b0;
    e_code[3] = 2'd0; e_row[3] = 5'd0; e_col[3] = 5'd2; e_last[3] = 1'b1;
    mem[{5'd2, 5'd4}] = 3'b010; mem[{5'd2, 5'd3}] = 3'b001;
    mem[{5'd1, 5'd3}] = 3'b000; mem[{5'd0, 5'd2}] = 3'b000;
    base = rd_cnt; d0 = done_cnt;
    do_start(5'd2, 5'd4);
    for (int i = 0; i < 4; i++) begin
      wait_op(code, r, c, last, got);
      total++;
      if (!got || code !== e_code[i] || r !== e_row[i] || c !== e_col[i] || last !== e_last[i]) begin
        bad++;
        $display("FAIL mixed_op%0d: got v=%0d code=%0d (%0d,%0d) last=%0d want code=%0d (%0d,%0d) last=%0d",
                 i, got, code, r, c, last, e_code[i], e_row[i], e_col[i], e_last[i]);
      end
      if (i == 1) begin
        op_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          total++;
          if (!op_valid || op_code !== 2'd1 || op_row !== 5'd2 || op_col !== 5'd3 || op_last !== 1'b0) begin
            bad++;
            $display("FAIL hold%0d: got v=%0d code=%0d (%0d,%0d) want v=1 code=1 (2,3)",
                     k, op_valid, op_code, op_row, op_col);
          end
        end
        op_ready = 1'b1;
      end
    end
    wait_idle(ok);
    total++;
    if (!ok || done_cnt - d0 != 1 || step_count !== 6'd4) begin
      bad++;
      $display("FAIL mixed_end: idle=%0d done=%0d steps=%0d want 1 1 4", ok, done_cnt - d0, step_count);
    end
    total++;
    if (rd_cnt - base != 4) begin
      bad++; $display("FAIL mixed_reads: got %0d want 4", rd_cnt - base);
    end
  endtask

  task automatic test_zero_start();
    bit ok; int base, d0, o0;
    mem[{5'd5, 5'd7}] = 3'b100;
    base = rd_cnt; d0 = done_cnt; o0 = opv_cnt;
    do_start(5'd5, 5'd7);
    wait_idle(ok);
    total++;
    if (!ok || rd_cnt - base != 1 || opv_cnt != o0 || done_cnt - d0 != 1 || step_count !== 6'd0) begin
      bad++;
      $display("FAIL zero_start: idle=%0d reads=%0d ops=%0d done=%0d steps=%0d want 1 1 0 1 0",
               ok, rd_cnt - base, opv_cnt - o0, done_cnt - d0, step_count);
    end
  endtask

  task automatic test_reserved();
    logic [1:0] code; logic [4:0] r, c; logic last; bit got, ok; int d0, e0;
    mem[{5'd4, 5'd4}] = 3'b000; mem[{5'd3, 5'd3}] = 3'b011;
    d0 = done_cnt; e0 = err_cnt;
    do_start(5'd4, 5'd4);
    wait_op(code, r, c, last, got);
    total++;
    if (!got || code !== 2'd0 || r !== 5'd4 || c !== 5'd4) begin
      bad++; $display("FAIL rsvd_op: got v=%0d code=%0d (%0d,%0d) want code=0 (4,4)", got, code, r, c);
    end
    wait_idle(ok);
    total++;
    if (!ok || err_cnt - e0 != 1 || done_cnt != d0 || step_count !== 6'd1) begin
      bad++;
      $display("FAIL rsvd_end: idle=%0d err=%0d done=%0d steps=%0d want 1 1 0 1",
               ok, err_cnt - e0, done_cnt - d0, step_count);
    end
  endtask

  task automatic test_abort();
    logic [1:0] code; logic [4:0] r, c; logic last; bit got, ok; int base, d0, e0, o0;
    // abort while the read is in flight
    mem[{5'd6, 5'd6}] = 3'b000; mem[{5'd3, 5'd3}] = 3'b000;
    rd_lat = 4;
    base = rd_cnt; d0 = done_cnt; e0 = err_cnt; o0 = opv_cnt;
    do_start(5'd6, 5'd6);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b1 || rd_req !== 1'b0) begin
      bad++; $display("FAIL drain_hold: got busy=%0d rd_req=%0d want 1 0", busy, rd_req);
    end
    wait_idle(ok);
    total++;
    if (!ok || opv_cnt != o0 || done_cnt != d0 || err_cnt != e0 || rd_cnt - base != 1) begin
      bad++;
      $display("FAIL drain_end: idle=%0d ops=%0d done=%0d err=%0d reads=%0d want 1 0 0 0 1",
               ok, opv_cnt - o0, done_cnt - d0, err_cnt - e0, rd_cnt - base);
    end
    rd_lat = 1;
    repeat (2) @(negedge clk);
    base = rd_cnt; d0 = done_cnt;
    do_start(5'd3, 5'd3);
    for (int i = 0; i < 3; i++) wait_op(code, r, c, last, got);
    wait_idle(ok);
    total++;
    if (!ok || done_cnt - d0 != 1 || step_count !== 6'd3 || addr_log[base % 256] !== 10'h063) begin
      bad++;
      $display("FAIL restart_walk: idle=%0d done=%0d steps=%0d addr0=%h want 1 1 3 063",
               ok, done_cnt - d0, step_count, addr_log[base % 256]);
    end
    // abort while an op is offered
    d0 = done_cnt; e0 = err_cnt;
    do_start(5'd3, 5'd3);
    wait_op(code, r, c, last, got);
    op_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (!got || op_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_emit: got op=%0d op_valid=%0d busy=%0d want 1 0 0", got, op_valid, busy);
    end
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt != d0 || err_cnt != e0) begin
      bad++; $display("FAIL abort_emit_pulse: done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
    op_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [1:0] code; logic [4:0] r, c; logic last; bit got, ok; int d0, o0;
    op_ready = 1'b0;
    do_start(5'd3, 5'd3);
    wait_op(code, r, c, last, got);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (!got || {rd_req, op_valid, op_last, busy, done, err} !== 6'b0 ||
        {op_code, op_row, op_col, step_count, rd_addr} !== 28'h0) begin
      bad++;
      $display("FAIL async_reset: got op=%0d ctrl=%b data=%h want 1 000000 0", got,
               {rd_req, op_valid, op_last, busy, done, err},
               {op_code, op_row, op_col, step_count, rd_addr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    op_ready = 1'b1;
    o0 = opv_cnt;
    inj_seq = inj_seq + 1;
    repeat (3) @(negedge clk);
    total++;
    if (opv_cnt != o0 || busy !== 1'b0) begin
      bad++; $display("FAIL stale_rd: ops=%0d busy=%0d want 0 0", opv_cnt - o0, busy);
    end
    mem[{5'd2, 5'd2}] = 3'b000; mem[{5'd1, 5'd1}] = 3'b000; mem[{5'd0, 5'd0}] = 3'b100;
    d0 = done_cnt;
    do_start(5'd2, 5'd2);
    wait_op(code, r, c, last, got);
    total++;
    if (!got || code !== 2'd0 || r !== 5'd2 || c !== 5'd2) begin
      bad++; $display("FAIL post_reset_op: got v=%0d code=%0d (%0d,%0d) want code=0 (2,2)", got, code, r, c);
    end
    wait_idle(ok);
    total++;
    if (!ok || done_cnt - d0 != 1 || step_count !== 6'd2) begin
      bad++;
      $display("FAIL post_reset_end: idle=%0d done=%0d steps=%0d want 1 1 2", ok, done_cnt - d0, step_count);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 3'b100;
    test_reset();
    test_diag_run();
    test_mixed_backpressure();
    test_zero_start();
    test_reserved();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
